// File: rtl/cache_tag_lookup_ctrl_if.sv
// Request, refill and tag-RAM signal bundle for cache_tag_lookup_ctrl.
// flush/flush_busy exist only when CACHE_TAG_FLUSH_EN is defined.
interface cache_tag_lookup_ctrl_if #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 4
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    logic                req_valid;
    logic                req_ready;
    logic [ADDR_W-1:0]   req_addr;
    logic                resp_valid;
    logic                resp_hit;
    logic                refill_req_valid;
    logic                refill_req_ready;
    logic [ADDR_W-1:0]   refill_req_addr;
    logic                refill_done;
    logic [INDEX_W-1:0]  tag_a;
    logic [TAG_W:0]      tag_d;
    logic                tag_we;
    logic [TAG_W:0]      tag_spo;
`ifdef CACHE_TAG_FLUSH_EN
    logic                flush;
    logic                flush_busy;
`endif

    // Controller side
    modport master (
        input  req_valid, req_addr, refill_req_ready, refill_done, tag_spo,
`ifdef CACHE_TAG_FLUSH_EN
        input  flush,
        output flush_busy,
`endif
        output req_ready, resp_valid, resp_hit, refill_req_valid, refill_req_addr,
               tag_a, tag_d, tag_we
    );

    // Requester / memory / tag RAM side
    modport slave (
        output req_valid, req_addr, refill_req_ready, refill_done, tag_spo,
`ifdef CACHE_TAG_FLUSH_EN
        output flush,
        input  flush_busy,
`endif
        input  req_ready, resp_valid, resp_hit, refill_req_valid, refill_req_addr,
               tag_a, tag_d, tag_we
    );
endinterface

// File: rtl/cache_tag_lookup_ctrl.sv
// Tag lookup/refill controller for a 32-set tag+valid RAM with registered-address read.
// Latency: hit responds 1 cycle after accept; miss responds in FILL after refill handshake + refill_done.
// Backpressure: one request in flight (req_ready low until response); refill request held until ready.
// Optional invalidate-all sequencer enabled by macro CACHE_TAG_FLUSH_EN.
module cache_tag_lookup_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cache_tag_lookup_ctrl_if.master bus
);
    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINE_W = ADDR_W - OFFSET_W;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOOKUP    = 3'd1;
    localparam logic [2:0] ST_MISS_REQ  = 3'd2;
    localparam logic [2:0] ST_MISS_WAIT = 3'd3;
    localparam logic [2:0] ST_FILL      = 3'd4;
`ifdef CACHE_TAG_FLUSH_EN
    localparam logic [2:0] ST_FLUSH     = 3'd5;
`endif

    logic [2:0]         state_q, state_d;
    // Only the line address is kept; the byte offset never matters after accept.
    logic [LINE_W-1:0]  addr_q, addr_d;

    logic [INDEX_W-1:0] req_idx;
    logic [INDEX_W-1:0] cur_idx;
    logic [TAG_W-1:0]   cur_tag;
    logic               lookup_hit;

    assign req_idx    = bus.req_addr[OFFSET_W +: INDEX_W];
    assign cur_idx    = addr_q[INDEX_W-1:0];
    assign cur_tag    = addr_q[LINE_W-1:INDEX_W];
    assign lookup_hit = bus.tag_spo[TAG_W] && (bus.tag_spo[TAG_W-1:0] == cur_tag);

    assign bus.refill_req_addr = {addr_q, {OFFSET_W{1'b0}}};

`ifdef CACHE_TAG_FLUSH_EN
    logic               flush_pend_q, flush_pend_d;
    logic [INDEX_W-1:0] flush_cnt_q, flush_cnt_d;
    logic               flush_clr;
    logic               flush_last;

    assign flush_last   = (flush_cnt_q == {INDEX_W{1'b1}});
    // A new flush pulse on the final sweep cycle stays pending and triggers another sweep.
    assign flush_pend_d = (flush_pend_q && !flush_clr) || bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend_q <= 1'b0;
            flush_cnt_q  <= '0;
        end else begin
            flush_pend_q <= flush_pend_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        addr_d               = addr_q;
        bus.req_ready        = 1'b0;
        bus.resp_valid       = 1'b0;
        bus.resp_hit         = 1'b0;
        bus.refill_req_valid = 1'b0;
        bus.tag_we           = 1'b0;
        bus.tag_d            = '0;
        bus.tag_a            = cur_idx;
`ifdef CACHE_TAG_FLUSH_EN
        bus.flush_busy       = 1'b0;
        flush_cnt_d          = flush_cnt_q;
        flush_clr            = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                // Present the incoming index now so the RAM read data is ready in LOOKUP.
                bus.tag_a = req_idx;
`ifdef CACHE_TAG_FLUSH_EN
                if (flush_pend_q) begin
                    flush_cnt_d = '0;
                    state_d     = ST_FLUSH;
                end else begin
                    bus.req_ready = 1'b1;
                    if (bus.req_valid) begin
                        addr_d  = bus.req_addr[ADDR_W-1:OFFSET_W];
                        state_d = ST_LOOKUP;
                    end
                end
`else
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr[ADDR_W-1:OFFSET_W];
                    state_d = ST_LOOKUP;
                end
`endif
            end

            ST_LOOKUP: begin
                if (lookup_hit) begin
                    bus.resp_valid = 1'b1;
                    bus.resp_hit   = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    state_d = ST_MISS_REQ;
                end
            end

            ST_MISS_REQ: begin
                bus.refill_req_valid = 1'b1;
                if (bus.refill_req_ready) begin
                    state_d = ST_MISS_WAIT;
                end
            end

            ST_MISS_WAIT: begin
                if (bus.refill_done) begin
                    state_d = ST_FILL;
                end
            end

            ST_FILL: begin
                // Conflicting tags are simply overwritten; lines are never dirty here.
                bus.tag_we     = 1'b1;
                bus.tag_d      = {1'b1, cur_tag};
                bus.resp_valid = 1'b1;
                bus.resp_hit   = 1'b0;
                state_d        = ST_IDLE;
            end

`ifdef CACHE_TAG_FLUSH_EN
            ST_FLUSH: begin
                bus.tag_a      = flush_cnt_q;
                bus.tag_we     = 1'b1;
                bus.tag_d      = '0;
                bus.flush_busy = 1'b1;
                flush_cnt_d    = flush_cnt_q + 1'b1;
                if (flush_last) begin
                    flush_clr = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cache_tag_lookup_ctrl.sv
// Randomized bench for cache_tag_lookup_ctrl: a behavioural tag RAM plus a per-set entry model.
// Define CACHE_TAG_FLUSH_EN to also exercise the invalidate-all sweep.
module tb_cache_tag_lookup_ctrl;
    logic clk;
    logic rst_n;
    logic ram_clr;

    int n_checks = 0;
    int n_errors = 0;

    cache_tag_lookup_ctrl_if bus ();

    cache_tag_lookup_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tag RAM: write on posedge, registered read address, read sees same-edge write.
    logic [23:0] ram [32];
    logic [4:0]  ram_a_q;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 32; i++) ram[i] <= '0;
        end else if (bus.tag_we) begin
            ram[bus.tag_a] <= bus.tag_d;
        end
        ram_a_q <= bus.tag_a;
    end
    assign bus.tag_spo = ram[ram_a_q];

    // Expected content of every set: {valid, tag}.
    logic [23:0] me [32];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete request; the caller is 1 time unit after a posedge with the DUT idle.
    task automatic do_req(input logic [31:0] addr, input int rdy_dly, input int done_dly,
                          input bit abort);
        int          idx;
        logic [22:0] tg;
        logic [31:0] line;
        bit          exp_hit;
        idx     = int'((addr >> 4) % 32);
        tg      = 23'(addr >> 9);
        line    = (addr >> 4) << 4;
        exp_hit = me[idx][23] && (me[idx][22:0] == tg);

        check_eq("idle_req_ready", bus.req_ready, 1);
        check_eq("idle_tag_we", bus.tag_we, 0);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        check_eq("lookup_req_ready", bus.req_ready, 0);
        check_eq("lookup_resp_valid", bus.resp_valid, 32'(exp_hit));
        check_eq("lookup_refill_vld", bus.refill_req_valid, 0);
        if (exp_hit) begin
            check_eq("hit_resp_hit", bus.resp_hit, 1);
            tick();
        end else begin
            tick();
            for (int k = 0; k <= rdy_dly; k++) begin
                check_eq("refill_vld", bus.refill_req_valid, 1);
                check_eq("refill_addr", bus.refill_req_addr, line);
                check_eq("miss_req_ready", bus.req_ready, 0);
                check_eq("miss_resp_valid", bus.resp_valid, 0);
                bus.refill_req_ready = (k == rdy_dly);
                tick();
            end
            bus.refill_req_ready = 1'b0;
            check_eq("refill_vld_after_hs", bus.refill_req_valid, 0);
            if (abort) begin
                rst_n = 1'b0;
                #1;
                check_eq("abort_refill_vld", bus.refill_req_valid, 0);
                check_eq("abort_req_ready", bus.req_ready, 1);
                tick();
                rst_n = 1'b1;
                bus.refill_done = 1'b1;
                check_eq("late_done_tag_we", bus.tag_we, 0);
                tick();
                bus.refill_done = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    check_eq("post_abort_tag_we", bus.tag_we, 0);
                    check_eq("post_abort_resp_vld", bus.resp_valid, 0);
                    check_eq("post_abort_req_ready", bus.req_ready, 1);
                    tick();
                end
            end else begin
                for (int k = 0; k < done_dly; k++) begin
                    check_eq("wait_tag_we", bus.tag_we, 0);
                    check_eq("wait_resp_vld", bus.resp_valid, 0);
                    check_eq("wait_refill_vld", bus.refill_req_valid, 0);
                    check_eq("wait_req_ready", bus.req_ready, 0);
                    tick();
                end
                bus.refill_done = 1'b1;
                tick();
                bus.refill_done = 1'b0;
                check_eq("fill_tag_we", bus.tag_we, 1);
                check_eq("fill_tag_a", 32'(bus.tag_a), 32'(idx));
                check_eq("fill_tag_d", 32'(bus.tag_d), 32'({1'b1, tg}));
                check_eq("fill_resp_vld", bus.resp_valid, 1);
                check_eq("fill_resp_hit", bus.resp_hit, 0);
                check_eq("fill_req_ready", bus.req_ready, 0);
                me[idx] = {1'b1, tg};
                tick();
            end
        end
    endtask

    logic [22:0] tg_pool [4];

    initial begin
        logic [31:0] a;
        bus.req_valid        = 1'b0;
        bus.req_addr         = '0;
        bus.refill_req_ready = 1'b0;
        bus.refill_done      = 1'b0;
`ifdef CACHE_TAG_FLUSH_EN
        bus.flush            = 1'b0;
`endif
        for (int i = 0; i < 32; i++) me[i] = '0;
        tg_pool[0] = 23'h9;
        tg_pool[1] = 23'h19;
        tg_pool[2] = 23'h7ABCD;
        tg_pool[3] = 23'($urandom);

        rst_n   = 1'b0;
        ram_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", bus.req_ready, 1);
        check_eq("rst_resp_valid", bus.resp_valid, 0);
        check_eq("rst_resp_hit", bus.resp_hit, 0);
        check_eq("rst_refill_vld", bus.refill_req_valid, 0);
        check_eq("rst_tag_we", bus.tag_we, 0);
        check_eq("rst_tag_d", 32'(bus.tag_d), 0);
        check_eq("rst_refill_addr", bus.refill_req_addr, 0);
`ifdef CACHE_TAG_FLUSH_EN
        check_eq("rst_flush_busy", bus.flush_busy, 0);
`endif
        rst_n   = 1'b1;
        ram_clr = 1'b0;
        tick();

        // Cold miss, same-line hit, conflict with long refill stall, re-miss, abort by reset.
        do_req(32'h0000_1230, 0, 1, 1'b0);
        do_req(32'h0000_1234, 0, 0, 1'b0);
        do_req(32'h0000_3230, 5, 2, 1'b0);
        do_req(32'h0000_1230, 1, 0, 1'b0);
        do_req(32'h0000_5670, 0, 1, 1'b1);
        do_req(32'h0000_5670, 0, 0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                // Idle cycles with stray refill strobes that must be ignored.
                bus.refill_done      = 1'($urandom);
                bus.refill_req_ready = 1'($urandom);
                tick();
                check_eq("idle_stray_tag_we", bus.tag_we, 0);
                check_eq("idle_stray_resp_vld", bus.resp_valid, 0);
                check_eq("idle_stray_refill_vld", bus.refill_req_valid, 0);
                bus.refill_done      = 1'b0;
                bus.refill_req_ready = 1'b0;
                tick();
            end
            a = (32'(tg_pool[$urandom_range(0, 3)]) << 9) | (32'($urandom_range(0, 7)) << 4)
                | 32'($urandom_range(0, 15));
            do_req(a, $urandom_range(0, 5), $urandom_range(0, 4), 1'($urandom_range(0, 15) == 0));
        end

`ifdef CACHE_TAG_FLUSH_EN
        do_req(32'h0000_1230, 0, 0, 1'b0);
        check_eq("pre_flush_req_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_1238;
        tick();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b1;
        check_eq("flush_lookup_resp_vld", bus.resp_valid, 1);
        check_eq("flush_lookup_resp_hit", bus.resp_hit, 1);
        check_eq("flush_lookup_busy", bus.flush_busy, 0);
        tick();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b1;
        check_eq("flush_pend_req_ready", bus.req_ready, 0);
        check_eq("flush_pend_busy", bus.flush_busy, 0);
        check_eq("flush_pend_tag_we", bus.tag_we, 0);
        tick();
        bus.req_valid = 1'b0;
        for (int c = 0; c < 32; c++) begin
            check_eq("flush_busy", bus.flush_busy, 1);
            check_eq("flush_tag_we", bus.tag_we, 1);
            check_eq("flush_tag_a", 32'(bus.tag_a), 32'(c));
            check_eq("flush_tag_d", 32'(bus.tag_d), 0);
            check_eq("flush_req_ready", bus.req_ready, 0);
            tick();
        end
        check_eq("post_flush_busy", bus.flush_busy, 0);
        for (int i = 0; i < 32; i++) me[i] = '0;
        do_req(32'h0000_1230, 0, 0, 1'b0);
`endif

        for (int i = 0; i < 32; i++) begin
            check_eq("ram_entry", 32'(ram[i]), 32'(me[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
